// File: rtl/tile_map_writer.sv
// Tile map for tank collision: loads a 20x15 level from the level ROM, clears bricks hit by shells,
// and serves a combinational pixel-coordinate read port. Define STEEL_CRACK_EN to let a hit crack steel into brick.
module tile_map_writer #(
  parameter int MAP_W        = 20,
  parameter int MAP_H        = 15,
  parameter int TILE_SZ_LOG2 = 5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       load_start,
  output logic [8:0] rom_addr,
  input  logic [1:0] rom_data,
  input  logic       hit_valid,
  output logic       hit_ready,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  input  logic [9:0] rd_x,
  input  logic [9:0] rd_y,
  output logic [1:0] rd_tile,
  output logic       map_ready,
  output logic [8:0] bricks_destroyed
);

  localparam int         N_TILES  = MAP_W * MAP_H;
  localparam logic [8:0] LAST_IDX = 9'(N_TILES);
  localparam logic [8:0] CNT_MAX  = 9'h1FF;

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_HIT} state_t;

  state_t     state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic       map_ready_q, map_ready_d;
  logic [8:0] bricks_q, bricks_d;
  logic [8:0] hit_idx_q, hit_idx_d;
  logic       hit_oob_q, hit_oob_d;

  logic [1:0] tile_q [0:N_TILES-1];
  logic [1:0] tile_d [0:N_TILES-1];

  logic       wr_en;
  logic [8:0] wr_idx;
  logic [1:0] wr_data;
  logic [1:0] hit_tile;
  logic [8:0] rd_idx;
  logic       rd_oob;

  // Row stride of 20 tiles built from shifts: ty*16 + ty*4.
  function automatic logic [8:0] tile_index(input logic [9:0] px, input logic [9:0] py);
    logic [8:0] tx;
    logic [8:0] ty;
    tx = 9'(px[9:TILE_SZ_LOG2]);
    ty = 9'(py[9:TILE_SZ_LOG2]);
    return (ty << 4) + (ty << 2) + tx;
  endfunction

  function automatic logic out_of_map(input logic [9:0] px, input logic [9:0] py);
    return (9'(px[9:TILE_SZ_LOG2]) >= 9'(MAP_W)) || (9'(py[9:TILE_SZ_LOG2]) >= 9'(MAP_H));
  endfunction

  assign hit_tile = tile_q[hit_idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    map_ready_d = map_ready_q;
    bricks_d    = bricks_q;
    hit_idx_d   = hit_idx_q;
    hit_oob_d   = hit_oob_q;
    hit_ready   = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = idx_q - 9'd1;
    wr_data     = rom_data;
    case (state_q)
      S_LOAD: begin
        // ROM data lags the address by one cycle, so each cycle writes the previous index.
        wr_en = (idx_q != 9'd0);
        if (idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          map_ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 9'd1;
        end
      end
      S_IDLE: begin
        hit_ready = !load_start;
        if (load_start) begin
          state_d     = S_LOAD;
          map_ready_d = 1'b0;
          bricks_d    = '0;
          idx_d       = '0;
        end else if (hit_valid) begin
          hit_idx_d = tile_index(hit_x, hit_y);
          hit_oob_d = out_of_map(hit_x, hit_y);
          state_d   = S_HIT;
        end
      end
      S_HIT: begin
        state_d = S_IDLE;
        wr_idx  = hit_idx_q;
        if (!hit_oob_q) begin
          case (hit_tile)
            2'd1: begin
              wr_en   = 1'b1;
              wr_data = 2'd0;
              if (bricks_q != CNT_MAX) bricks_d = bricks_q + 9'd1;
            end
`ifdef STEEL_CRACK_EN
            2'd2: begin
              wr_en   = 1'b1;
              wr_data = 2'd1;
            end
`endif
            default: ;
          endcase
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_TILES; gi++) begin : g_tile
      assign tile_d[gi] = (wr_en && (wr_idx == 9'(gi))) ? wr_data : tile_q[gi];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      map_ready_q <= 1'b0;
      bricks_q    <= '0;
      hit_idx_q   <= '0;
      hit_oob_q   <= 1'b0;
      for (int i = 0; i < N_TILES; i++) tile_q[i] <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      map_ready_q <= map_ready_d;
      bricks_q    <= bricks_d;
      hit_idx_q   <= hit_idx_d;
      hit_oob_q   <= hit_oob_d;
      tile_q      <= tile_d;
    end
  end

  // Unloaded map and off-screen coordinates read as steel so tanks cannot move there.
  assign rd_idx  = tile_index(rd_x, rd_y);
  assign rd_oob  = out_of_map(rd_x, rd_y);
  assign rd_tile = (!map_ready_q || rd_oob) ? 2'd2 : tile_q[rd_idx];

  assign rom_addr         = idx_q;
  assign map_ready        = map_ready_q;
  assign bricks_destroyed = bricks_q;

endmodule
